// File: rtl/md_pkg.sv
// Shared types and sizing for the MULT/DIV sequencer (SIGNED_MD_EN selects signed support).
package md_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } md_state_t;

endpackage

// File: rtl/md_sign_fix.sv
// Combinational operand magnitude extraction and result sign restoration.
// Only instantiated when SIGNED_MD_EN is defined.
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             op_signed_i,
  output logic [WIDTH-1:0] mag_a_o,
  output logic [WIDTH-1:0] mag_b_o,
  output logic             neg_a_o,
  output logic             neg_b_o,
  input  logic [WIDTH-1:0] res_hi_i,
  input  logic [WIDTH-1:0] res_lo_i,
  input  logic             is_div_i,
  input  logic             neg_quot_i,
  input  logic             neg_rem_i,
  output logic [WIDTH-1:0] fix_hi_o,
  output logic [WIDTH-1:0] fix_lo_o
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  assign neg_a_o = op_signed_i & op_a_i[WIDTH-1];
  assign neg_b_o = op_signed_i & op_b_i[WIDTH-1];
  assign mag_a_o = neg_a_o ? (~op_a_i + WIDTH'(1)) : op_a_i;
  assign mag_b_o = neg_b_o ? (~op_b_i + WIDTH'(1)) : op_b_i;

  assign prod     = {res_hi_i, res_lo_i};
  assign prod_neg = ~prod + (2*WIDTH)'(1);

  // Remainder follows the dividend sign; quotient/product follow sign mismatch.
  always_comb begin
    fix_hi_o = prod[2*WIDTH-1:WIDTH];
    fix_lo_o = prod[WIDTH-1:0];
    if (is_div_i) begin
      fix_lo_o = neg_quot_i ? (~res_lo_i + WIDTH'(1)) : res_lo_i;
      fix_hi_o = neg_rem_i  ? (~res_hi_i + WIDTH'(1)) : res_hi_i;
    end else if (neg_quot_i) begin
      fix_hi_o = prod_neg[2*WIDTH-1:WIDTH];
      fix_lo_o = prod_neg[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// Iterative shift-add multiplier / restoring divider owning HI/LO, one bit per cycle.
// Signed MULT/DIV handling is compiled in only when SIGNED_MD_EN is defined.
module mult_div_ctrl
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITERS = MD_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  md_state_t          state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] sr_q;
  logic [WIDTH-1:0]   opb_q;
  logic               busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic [2*WIDTH-1:0] step_d;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic               accept;
  logic               last_iter;

  assign accept    = (state_q == IDLE) && (start_mult || start_div);
  assign last_iter = (cnt_q == CW'(ITERS - 1));

  // One iteration: MULT adds the multiplicand into the upper half and shifts
  // right; DIV shifts left and conditionally subtracts the divisor.
  always_comb begin
    mul_sum = {1'b0, sr_q[2*WIDTH-1:WIDTH]} + (sr_q[0] ? {1'b0, opb_q} : '0);
    rem_sh  = {sr_q[2*WIDTH-1:WIDTH], sr_q[WIDTH-1]};
    div_ge  = (rem_sh >= {1'b0, opb_q});
    div_rem = div_ge ? (rem_sh[WIDTH-1:0] - opb_q) : rem_sh[WIDTH-1:0];
    step_d  = {mul_sum, sr_q[WIDTH-1:1]};
    if (state_q == DIV) begin
      step_d = {div_rem, sr_q[WIDTH-2:0], div_ge};
    end
  end

`ifdef SIGNED_MD_EN
  logic neg_a, neg_b;
  logic neg_quot_q, neg_rem_q;

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .op_signed_i (op_signed),
    .mag_a_o     (mag_a),
    .mag_b_o     (mag_b),
    .neg_a_o     (neg_a),
    .neg_b_o     (neg_b),
    .res_hi_i    (step_d[2*WIDTH-1:WIDTH]),
    .res_lo_i    (step_d[WIDTH-1:0]),
    .is_div_i    (state_q == DIV),
    .neg_quot_i  (neg_quot_q),
    .neg_rem_i   (neg_rem_q),
    .fix_hi_o    (fix_hi),
    .fix_lo_o    (fix_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (accept) begin
      neg_quot_q <= neg_a ^ neg_b;
      neg_rem_q  <= neg_a;
    end
  end
`else
  logic unused_sgn;

  assign unused_sgn = op_signed;
  assign mag_a      = op_a;
  assign mag_b      = op_b;
  assign fix_hi     = step_d[2*WIDTH-1:WIDTH];
  assign fix_lo     = step_d[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      opb_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q     <= 1'b0;
          div_zero_q <= 1'b0;
          cnt_q      <= '0;
          if (start_mult) begin
            state_q <= MULT;
            busy_q  <= 1'b1;
            sr_q    <= {{WIDTH{1'b0}}, mag_a};
            opb_q   <= mag_b;
          end else if (start_div) begin
            if (op_b == '0) begin
              // Zero divisor: report immediately, HI/LO untouched.
              state_q    <= FIN;
              done_q     <= 1'b1;
              div_zero_q <= 1'b1;
            end else begin
              state_q <= DIV;
              busy_q  <= 1'b1;
              sr_q    <= {{WIDTH{1'b0}}, mag_a};
              opb_q   <= mag_b;
            end
          end
        end
        MULT, DIV: begin
          sr_q  <= step_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= fix_hi;
            lo_q    <= fix_lo;
          end
        end
        FIN: begin
          state_q    <= IDLE;
          done_q     <= 1'b0;
          div_zero_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl; signed vectors run when SIGNED_MD_EN is defined.
module tb_mult_div_ctrl;

  localparam int ITERS = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult, start_div, op_signed;
  logic [31:0] op_a, op_b;
  logic        busy, done, div_zero;
  logic [31:0] hi_out, lo_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
    int          busy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;

  mult_div_ctrl #(.WIDTH(32), .ITERS(ITERS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .op_signed  (op_signed),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 at cycle %0d with no pending op", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("hi_out",   hi_out, mon_e.hi);
          chk("lo_out",   lo_out, mon_e.lo);
          chk("div_zero", {31'b0, div_zero}, {31'b0, mon_e.dz});
          chk("done_cycle", cyc, mon_e.cyc);
          chk("busy_cycles", busy_cnt, mon_e.busy);
        end
        busy_cnt = 0;
      end
    end
  end

  // poke > 0: pulse both starts that many cycles into the operation.
  task automatic issue(input logic m, input logic d, input logic sg,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edz, input int poke);
    exp_t e;
    bit   seen;
    @(posedge clk); #1;
    start_mult = m; start_div = d; op_signed = sg; op_a = a; op_b = b;
    @(posedge clk); #1;
    e.hi = ehi; e.lo = elo; e.dz = edz;
    // Zero divisor finishes in the cycle right after accept.
    e.cyc  = edz ? cyc : cyc + ITERS;
    e.busy = edz ? 0 : ITERS;
    sb.push_back(e);
    start_mult = 1'b0; start_div = 1'b0;
    if (poke > 0) begin
      repeat (poke) @(posedge clk);
      #1 start_mult = 1'b1; start_div = 1'b1; op_b = 32'h0;
      @(posedge clk); #1 start_mult = 1'b0; start_div = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done for a=%h b=%h", a, b);
      if (sb.size() > 0) e = sb.pop_back();
    end
  endtask

  initial begin
    reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; op_signed = 1'b0;
    op_a = 32'h0; op_b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_div_zero", {31'b0, div_zero}, 32'h0);
    chk("rst_hi", hi_out, 32'h0);
    chk("rst_lo", lo_out, 32'h0);
    reset = 1'b0;

    issue(1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 0);
    issue(0, 1, 0, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0);
    issue(0, 1, 1, 32'd100, 32'd0, 32'd2, 32'd14, 1, 0);
    issue(1, 1, 0, 32'd6, 32'd7, 32'd0, 32'd42, 0, 5);
    issue(1, 0, 0, 32'h00010000, 32'h00010000, 32'h1, 32'h0, 0, 0);
    issue(0, 1, 0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF, 0, 0);
    issue(0, 1, 0, 32'd5, 32'd9, 32'd5, 32'd0, 0, 0);
    issue(0, 1, 0, 32'd0, 32'd0, 32'd5, 32'd0, 1, 0);
`ifdef SIGNED_MD_EN
    issue(1, 0, 1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 0);
    issue(0, 1, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
    issue(0, 1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, 0);
    issue(0, 1, 1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 0, 0);
    issue(1, 0, 1, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h0, 32'd6, 0, 0);
    issue(0, 1, 0, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, 0, 0);
`else
    issue(1, 0, 1, 32'hFFFFFFFD, 32'd5, 32'h4, 32'hFFFFFFF1, 0, 0);
    issue(0, 1, 1, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, 0, 0);
`endif

    // Abort a multiply ten iterations in; no done may follow.
    @(posedge clk); #1;
    op_a = 32'd3; op_b = 32'd3; op_signed = 1'b0; start_mult = 1'b1;
    @(posedge clk); #1 start_mult = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_hi", hi_out, 32'h0);
    chk("abort_lo", lo_out, 32'h0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_idle_busy", {31'b0, busy}, 32'h0);
    chk("pending_ops", sb.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
